// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable data width and stop length,
// framing/break/glitch handling. Optional parity checking via `UART_RX_PARITY_EN.
module uart_rx_cfg #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    input  logic            parity_odd,
    output logic [DBIT-1:0] rx_dataOut,
    output logic            rx_doneTick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            break_det,
    output logic            busy
);

    localparam int CMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = $clog2(CMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] HALF_LAST = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(OVS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [SW-1:0]     s_cnt_q, s_cnt_d;
    logic [NW-1:0]     n_q, n_d;
    logic [DBIT-1:0]   b_q, b_d;
    logic [DBIT-1:0]   data_q, data_d;
    logic              done_q, done_d;
    logic              frame_err_q, frame_err_d;
    logic              break_q, break_d;
    logic              busy_q, busy_d;
    logic              p_v;
    logic              brk_now;

`ifdef UART_RX_PARITY_EN
    logic              p_q, p_d;
    logic              parity_err_q, parity_err_d;
    assign p_v = p_q;
`else
    logic              unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign p_v = 1'b0;
`endif

    // A stop bit sampled low over an all-zero word (and zero parity) is a break.
    assign brk_now = ~rx_s_q & (b_q == '0) & ~p_v;

    always_comb begin
        state_d     = state_q;
        s_cnt_d     = s_cnt_q;
        n_d         = n_q;
        b_d         = b_q;
        data_d      = data_q;
        done_d      = 1'b0;
        frame_err_d = frame_err_q;
        break_d     = break_q;
`ifdef UART_RX_PARITY_EN
        p_d          = p_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == HALF_LAST) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        b_d     = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        p_d     = rx_s_q;
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        data_d      = b_q;
                        frame_err_d = ~rx_s_q;
                        break_d     = brk_now;
                        done_d      = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ((^b_q) ^ p_q) != parity_odd;
`endif
                        state_d = brk_now ? BRK_WAIT : IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            BRK_WAIT: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            s_cnt_q     <= '0;
            n_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_q          <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            s_cnt_q     <= s_cnt_d;
            n_q         <= n_d;
            b_q         <= b_d;
            data_q      <= data_d;
            done_q      <= done_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            p_q          <= p_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_dataOut  = data_q;
    assign rx_doneTick = done_q;
    assign frame_err   = frame_err_q;
    assign break_det   = break_q;
    assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames push expected words,
// a monitor pops and compares on every rx_doneTick.
module tb_uart_rx_cfg;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx = 1'b1;
    logic       parity_odd = 1'b0;
    logic [7:0] rx_dataOut;
    logic       rx_doneTick, frame_err, parity_err, break_det, busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       brk;
        logic       cb;
    } exp_t;

    exp_t q[$];

    uart_rx_cfg #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_tick     (s_tick),
        .rx         (rx),
        .parity_odd (parity_odd),
        .rx_dataOut (rx_dataOut),
        .rx_doneTick(rx_doneTick),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .break_det  (break_det),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe,
                                input logic brk, input logic cb);
        exp_t e;
        e.d = d; e.fe = fe; e.pe = pe; e.brk = brk; e.cb = cb;
        q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int stop_clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        repeat (BIT) @(negedge clk);
`else
        if (par) rx = 1'b1;
`endif
        rx = stop;
        repeat (stop_clk) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    // Monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rx_doneTick) begin
            chk("strobe_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("data", 32'(rx_dataOut), 32'(e.d));
                chk("frame_err", 32'(frame_err), 32'(e.fe));
                chk("parity_err", 32'(parity_err), 32'(e.pe));
                chk("break_det", 32'(break_det), 32'(e.brk));
                if (e.cb) begin
                    repeat (2) @(negedge clk);
                    chk("busy_after_strobe", 32'(busy), 32'd0);
                end
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_outputs", 32'({rx_dataOut, rx_doneTick, frame_err, parity_err, break_det, busy}), 32'd0);
        reset_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Good frame.
        expect_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, BIT);
        repeat (BIT) @(negedge clk);

        // Stop bit low, then a good frame clears the error.
        expect_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 44);
        repeat (2 * BIT) @(negedge clk);
        expect_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, BIT);
        repeat (BIT) @(negedge clk);

        // Break: line low for three frame times.
        expect_frame(8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        rx = 1'b0;
        repeat (3 * 11 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("busy_after_break", 32'(busy), 32'd0);
        expect_frame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA3, 1'b0, 1'b1, BIT);
        repeat (BIT) @(negedge clk);

        // Glitch: 5 ticks low.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_glitch_high", 32'(busy), 32'd1);
        repeat (70) @(negedge clk);
        chk("busy_glitch_low", 32'(busy), 32'd0);
        repeat (2 * BIT) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        expect_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b1, BIT);
        repeat (BIT) @(negedge clk);
        expect_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b1, BIT);
        repeat (BIT) @(negedge clk);
        parity_odd = 1'b1;
        expect_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b1, BIT);
        repeat (BIT) @(negedge clk);
        parity_odd = 1'b0;
`endif

        // Reset during data bit 3 of 0x81: frame discarded.
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        rx = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        repeat (BIT / 2) @(negedge clk);
        chk("busy_before_abort", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({rx_dataOut, rx_doneTick, frame_err, parity_err, break_det, busy}), 32'd0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * 11 * BIT) @(negedge clk);
        chk("busy_after_abort", 32'(busy), 32'd0);
        expect_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1, BIT);

        repeat (4 * BIT) @(negedge clk);
        chk("pending_strobes", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
